// File: rtl/equiv_stim_sequencer.sv
// Pseudo-random stimulus sequencer and output comparator for a dual-implementation equivalence harness.
// Optional macro STOP_ON_FAIL_EN ends a run on the first mismatching compare slot.
module equiv_stim_sequencer #(
    parameter int          IN0_W    = 17,
    parameter int          IN1_W    = 22,
    parameter int          IN2_W    = 21,
    parameter int          IN3_W    = 18,
    parameter int          OUT_W    = 91,
    parameter int          NUM_VEC  = 1024,
    parameter int          LAT      = 2,
    parameter logic [31:0] SEED_DEF = 32'hACE1_2025
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      seed,
    output logic [IN0_W-1:0] stim0,
    output logic [IN1_W-1:0] stim1,
    output logic [IN2_W-1:0] stim2,
    output logic [IN3_W-1:0] stim3,
    input  logic [OUT_W-1:0] y_1,
    input  logic [OUT_W-1:0] y_2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      mismatch_cnt,
    output logic [15:0]      first_fail_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [31:0] TAPS       = 32'h8020_0003;
    localparam logic [15:0] LAST_IDX   = 16'(NUM_VEC - 1);
    localparam logic [3:0]  LAST_DRAIN = 4'(LAT - 1);

    state_t              state;
    logic [31:0]         lfsr;
    logic [31:0]         lfsr_next;
    logic [15:0]         vec_idx;
    logic [3:0]          drain_cnt;
    logic [LAT:0]        pipe_vld;
    logic [LAT:0][15:0]  pipe_idx;
    logic [IN2_W-1:0]    stim2_d;
    logic [IN3_W-1:0]    stim3_d;
    logic                hit;
    logic [15:0]         cnt_inc;

    always_comb begin
        lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
        stim2_d = '0;
        for (int i = 0; i < IN2_W; i++) begin
            stim2_d[i] = lfsr[IN2_W-1-i];
        end
        stim3_d = '0;
        for (int i = 0; i < IN3_W; i++) begin
            stim3_d[i] = lfsr[i] ^ lfsr[(i + 16) % 32];
        end
        // The oldest pipeline stage marks the cycle whose outputs belong to a driven vector.
        hit = pipe_vld[LAT] && (y_1 != y_2);
        cnt_inc = (hit && (mismatch_cnt != 16'hFFFF)) ? mismatch_cnt + 16'd1 : mismatch_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            lfsr           <= SEED_DEF;
            vec_idx        <= '0;
            drain_cnt      <= '0;
            pipe_vld       <= '0;
            pipe_idx       <= '0;
            stim0          <= '0;
            stim1          <= '0;
            stim2          <= '0;
            stim3          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_idx <= 16'hFFFF;
        end else if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            pipe_vld <= '0;
            stim0    <= '0;
            stim1    <= '0;
            stim2    <= '0;
            stim3    <= '0;
        end else if (start && (state == IDLE || state == DONE)) begin
            state          <= RUN;
            lfsr           <= (seed == 32'h0) ? SEED_DEF : seed;
            vec_idx        <= '0;
            drain_cnt      <= '0;
            pipe_vld       <= '0;
            stim0          <= '0;
            stim1          <= '0;
            stim2          <= '0;
            stim3          <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_idx <= 16'hFFFF;
        end else begin
            for (int i = LAT; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            pipe_vld[0] <= (state == RUN);
            pipe_idx[0] <= vec_idx;
            if (hit) begin
                mismatch_cnt <= cnt_inc;
                if (first_fail_idx == 16'hFFFF) begin
                    first_fail_idx <= pipe_idx[LAT];
                end
            end
            case (state)
                IDLE: begin
                    stim0 <= '0;
                    stim1 <= '0;
                    stim2 <= '0;
                    stim3 <= '0;
                end
                RUN: begin
`ifdef STOP_ON_FAIL_EN
                    if (hit) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= 1'b0;
                        pipe_vld <= '0;
                    end else begin
`else
                    begin
`endif
                        stim0   <= lfsr[IN0_W-1:0];
                        stim1   <= lfsr[31 -: IN1_W];
                        stim2   <= stim2_d;
                        stim3   <= stim3_d;
                        lfsr    <= lfsr_next;
                        vec_idx <= vec_idx + 16'd1;
                        if (vec_idx == LAST_IDX) begin
                            if (LAT > 0) begin
                                state     <= DRAIN;
                                drain_cnt <= '0;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= (cnt_inc == 16'h0);
                            end
                        end
                    end
                end
                DRAIN: begin
`ifdef STOP_ON_FAIL_EN
                    if (hit) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= 1'b0;
                        pipe_vld <= '0;
                    end else begin
`else
                    begin
`endif
                        if (drain_cnt == LAST_DRAIN) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (cnt_inc == 16'h0);
                        end else begin
                            drain_cnt <= drain_cnt + 4'd1;
                        end
                    end
                end
                // The last vector's compare slot lands after DONE entry, so pass tracks it here.
                DONE: begin
                    pass <= (cnt_inc == 16'h0);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_equiv_stim_sequencer.sv
// Scoreboard bench for equiv_stim_sequencer: a behavioural LFSR/vector model feeds expected
// stimulus and run results into queues that negedge monitors drain and compare.
module tb_equiv_stim_sequencer;

    localparam int          NV       = 16;
    localparam int          LATM     = 2;
    localparam int          NVS      = 65535;
    localparam logic [31:0] SEED_DEF = 32'hACE1_2025;

    typedef struct {
        logic [15:0] cnt;
        logic [15:0] first;
        logic        pass;
        int          busy;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort;
    logic [31:0] seed;
    logic [16:0] stim0;
    logic [21:0] stim1;
    logic [20:0] stim2;
    logic [17:0] stim3;
    logic [90:0] y_1, y_2;
    logic        busy, done, pass;
    logic [15:0] mismatch_cnt, first_fail_idx;

    logic        start_s;
    logic        abort_s = 1'b0;
    logic [31:0] seed_s = 32'h0;
    logic [16:0] stim0_s;
    logic [21:0] stim1_s;
    logic [20:0] stim2_s;
    logic [17:0] stim3_s;
    logic [90:0] y_1s, y_2s;
    logic        busy_s, done_s, pass_s;
    logic [15:0] mismatch_cnt_s, first_fail_idx_s;

    int tests = 0;
    int fails = 0;
    logic sb_on = 1'b0;

    exp_t        exp_q[$];
    logic [77:0] vec_q[$];
    logic [77:0] bad_vecs[$];
    int          fail_set[$];

    equiv_stim_sequencer #(.NUM_VEC(NV), .LAT(LATM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
        .stim0(stim0), .stim1(stim1), .stim2(stim2), .stim3(stim3),
        .y_1(y_1), .y_2(y_2), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx)
    );

    equiv_stim_sequencer #(.NUM_VEC(NVS), .LAT(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s), .seed(seed_s),
        .stim0(stim0_s), .stim1(stim1_s), .stim2(stim2_s), .stim3(stim3_s),
        .y_1(y_1s), .y_2(y_2s), .busy(busy_s), .done(done_s), .pass(pass_s),
        .mismatch_cnt(mismatch_cnt_s), .first_fail_idx(first_fail_idx_s)
    );

    function automatic logic [31:0] step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [77:0] vec_of(input logic [31:0] l);
        logic [16:0] s0;
        logic [21:0] s1;
        logic [20:0] s2;
        logic [31:0] m;
        s0 = l[16:0];
        s1 = l[31:10];
        for (int i = 0; i < 21; i++) s2[i] = l[20-i];
        m = l ^ {l[15:0], l[31:16]};
        return {m[17:0], s2, s1, s0};
    endfunction

    function automatic logic is_bad(input logic [77:0] v);
        foreach (bad_vecs[i]) if (bad_vecs[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    // Two implementations with LATM register stages; y_2 flips bit 0 for the flagged vectors.
    logic [77:0] stim_cat, d1 = '0, d2 = '0;
    logic        bad1 = 1'b0, bad2 = 1'b0;
    assign stim_cat = {stim3, stim2, stim1, stim0};
    always @(posedge clk) begin
        d1   <= stim_cat;
        d2   <= d1;
        bad1 <= is_bad(stim_cat);
        bad2 <= bad1;
    end
    assign y_1 = {d2[12:0], d2};
    assign y_2 = y_1 ^ {90'b0, bad2};

    logic [77:0] cat_s;
    assign cat_s = {stim3_s, stim2_s, stim1_s, stim0_s};
    assign y_1s  = {cat_s[12:0], cat_s};
    assign y_2s  = ~y_1s;

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Stimulus monitor: every new nonzero vector on the bus is popped against the model.
    logic [77:0] prev_cat = '0;
    always @(negedge clk) begin
        if (sb_on && busy && stim_cat != prev_cat && stim_cat != '0) begin
            if (vec_q.size() == 0) checkOutput("stim_extra", 96'(stim_cat), 96'(0));
            else checkOutput("stim_vec", 96'(stim_cat), 96'(vec_q.pop_front()));
        end
        prev_cat = stim_cat;
    end

    // Result monitor: two cycles after done rises the run result is compared.
    int   busy_cnt = 0, busy_len = 0, tail = 0;
    logic done_prev = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        else if (busy_cnt != 0) begin
            busy_len = busy_cnt;
            busy_cnt = 0;
        end
        if (tail > 0) begin
            tail--;
            if (tail == 0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL done_unexpected: got done=1, expected no run");
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("run_cnt", 96'(mismatch_cnt), 96'(mon_e.cnt));
                    checkOutput("run_first", 96'(first_fail_idx), 96'(mon_e.first));
                    checkOutput("run_pass", 96'(pass), 96'(mon_e.pass));
                    checkOutput("run_busy_len", 96'(busy_len), 96'(mon_e.busy));
                    checkOutput("run_done_held", 96'(done), 96'(1));
                    checkOutput("run_vec_left", 96'(vec_q.size()), 96'(0));
                    vec_q.delete();
                end
            end
        end
        if (sb_on && done && !done_prev) tail = 2;
        done_prev = done;
    end

    // Long-run monitor: full LFSR stream against the model, nonzero check.
    logic [31:0] sat_l = SEED_DEF;
    logic [77:0] sat_prev = '0;
    int sat_vecs = 0, sat_err = 0, sat_zero = 0, sat_busy = 0;
    always @(negedge clk) begin
        if (busy_s) sat_busy++;
        if (busy_s || done_s) begin
            if (cat_s == '0) begin
                if (busy_s && sat_busy > 1) sat_zero++;
            end else if (cat_s != sat_prev) begin
                if (cat_s != vec_of(sat_l)) sat_err++;
                sat_l = step(sat_l);
                sat_vecs++;
            end
        end
        sat_prev = cat_s;
    end

    task automatic applyStimulus(input logic [31:0] sd);
        exp_t        e;
        logic [31:0] l;
        logic        hitk;
        logic [77:0] v;
        l = (sd == 32'h0) ? SEED_DEF : sd;
        bad_vecs.delete();
        e.cnt   = 16'h0;
        e.first = 16'hFFFF;
        for (int k = 0; k < NV; k++) begin
            v = vec_of(l);
            vec_q.push_back(v);
            hitk = 1'b0;
            foreach (fail_set[j]) if (fail_set[j] == k) hitk = 1'b1;
            if (hitk) begin
                bad_vecs.push_back(v);
                e.cnt = e.cnt + 16'd1;
                if (e.first == 16'hFFFF) e.first = 16'(k);
            end
            l = step(l);
        end
        e.pass = (e.cnt == 16'h0);
        e.busy = NV + LATM;
        exp_q.push_back(e);
        sb_on = 1'b1;
        seed  = sd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL run_timeout: got no result after 200 cycles, expected done");
            exp_q.delete();
            vec_q.delete();
        end
        sb_on = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] sd, l;
        logic [77:0] v7;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = 32'h0; start_s = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 96'(busy), 96'(0));
        checkOutput("reset_done", 96'(done), 96'(0));
        checkOutput("reset_pass", 96'(pass), 96'(0));
        checkOutput("reset_cnt", 96'(mismatch_cnt), 96'(0));
        checkOutput("reset_first", 96'(first_fail_idx), 96'(16'hFFFF));
        checkOutput("reset_stim", 96'(stim_cat), 96'(0));
        rst_n = 1'b1;
        @(negedge clk);

        fail_set.delete();
        applyStimulus(32'h0);
        fail_set = {5};
        applyStimulus($urandom());
        for (int r = 0; r < 4; r++) begin
            fail_set.delete();
            for (int n = $urandom_range(0, 3); n > 0; n--) fail_set.push_back(int'($urandom_range(0, NV - 1)));
            if (r == 2) fail_set.push_back(0);
            if (r == 3) fail_set.push_back(NV - 1);
            applyStimulus($urandom());
        end
        sd = $urandom() | 32'h1;
        fail_set.delete();
        applyStimulus(sd);
        applyStimulus(sd);

        // Abort at vector 7 after a mismatch on vector 2 has been counted.
        sd = $urandom() | 32'h1;
        l = sd;
        bad_vecs.delete();
        v7 = '0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) bad_vecs.push_back(vec_of(l));
            if (k == 7) v7 = vec_of(l);
            l = step(l);
        end
        seed = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("abort_stim_vec7", 96'(stim_cat), 96'(v7));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", 96'(busy), 96'(0));
        checkOutput("abort_done", 96'(done), 96'(0));
        checkOutput("abort_cnt_kept", 96'(mismatch_cnt), 96'(1));
        checkOutput("abort_first_kept", 96'(first_fail_idx), 96'(2));
        bad_vecs.delete();
        seed = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("restart_busy", 96'(busy), 96'(1));
        checkOutput("restart_cnt", 96'(mismatch_cnt), 96'(0));
        checkOutput("restart_first", 96'(first_fail_idx), 96'(16'hFFFF));
        @(negedge clk);
        checkOutput("restart_stim0", 96'(stim0), 96'(17'h00001));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Reset mid-run while start stays high.
        seed = 32'h0; start = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", 96'(busy), 96'(0));
        checkOutput("midrst_done", 96'(done), 96'(0));
        checkOutput("midrst_cnt", 96'(mismatch_cnt), 96'(0));
        checkOutput("midrst_first", 96'(first_fail_idx), 96'(16'hFFFF));
        checkOutput("midrst_stim", 96'(stim_cat), 96'(0));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_rerun_busy", 96'(busy), 96'(1));
        @(negedge clk);
        checkOutput("midrst_stim0_seeddef", 96'(stim0), 96'(17'h12025));
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Full-length run with every compare failing and no drain phase.
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int i = 0; i < NVS + 100 && !done_s; i++) @(negedge clk);
        checkOutput("sat_done", 96'(done_s), 96'(1));
        repeat (2) @(negedge clk);
        checkOutput("sat_cnt", 96'(mismatch_cnt_s), 96'(16'hFFFF));
        checkOutput("sat_first", 96'(first_fail_idx_s), 96'(0));
        checkOutput("sat_pass", 96'(pass_s), 96'(0));
        checkOutput("sat_busy_len", 96'(sat_busy), 96'(NVS));
        checkOutput("sat_vecs", 96'(sat_vecs), 96'(NVS));
        checkOutput("sat_stream_err", 96'(sat_err), 96'(0));
        checkOutput("sat_lfsr_zero", 96'(sat_zero), 96'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
